// File: rtl/cpu_pkg.sv
// Shared constants and types for the hardwired control sequencer:
// opcodes, ALU codes, FSM state encoding and the control-strobe bundle.
package cpu_pkg;

  localparam int unsigned IR_W  = 32;
  localparam int unsigned OPC_W = 5;
  localparam int unsigned ALU_W = 5;
  localparam int unsigned GR_W  = 4;

  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  localparam logic [ALU_W-1:0] ALU_NOP = 5'h00;
  localparam logic [ALU_W-1:0] ALU_ADD = 5'h03;
  localparam logic [ALU_W-1:0] ALU_SUB = 5'h04;
  localparam logic [ALU_W-1:0] ALU_AND = 5'h05;
  localparam logic [ALU_W-1:0] ALU_OR  = 5'h06;

  // Field mask handed to select-and-encode when a register field is selected
  localparam logic [GR_W-1:0] GR_SEL = 4'hF;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } ctrl_state_t;

  typedef enum logic [3:0] {
    CLS_ALU_RR  = 4'd0,
    CLS_ALU_IMM = 4'd1,
    CLS_LDI     = 4'd2,
    CLS_LD      = 4'd3,
    CLS_ST      = 4'd4,
    CLS_JR      = 4'd5,
    CLS_NOP     = 4'd6,
    CLS_HALT    = 4'd7,
    CLS_ILLEGAL = 4'd8
  } instr_class_t;

  typedef struct packed {
    logic             pc_out;
    logic             zlow_out;
    logic             mdr_out;
    logic             c_out;
    logic             mar_in;
    logic             mdr_in;
    logic             pc_in;
    logic             ir_in;
    logic             y_in;
    logic             z_in;
    logic             inc_pc;
    logic             read;
    logic             write;
    logic [GR_W-1:0]  gra;
    logic [GR_W-1:0]  grb;
    logic [GR_W-1:0]  grc;
    logic             r_in;
    logic             r_out;
    logic             ba_out;
    logic [ALU_W-1:0] alu_op;
  } ctrl_out_t;

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode decode: instruction class and the ALU code used in T4.
module ctrl_opdecode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output instr_class_t     instr_class_c,
  output logic [ALU_W-1:0] alu_op_c
);

  always_comb begin
    instr_class_c = CLS_ILLEGAL;
    alu_op_c      = ALU_NOP;
    case (opcode)
      OP_ADD:  begin instr_class_c = CLS_ALU_RR;  alu_op_c = ALU_ADD; end
      OP_SUB:  begin instr_class_c = CLS_ALU_RR;  alu_op_c = ALU_SUB; end
      OP_AND:  begin instr_class_c = CLS_ALU_RR;  alu_op_c = ALU_AND; end
      OP_OR:   begin instr_class_c = CLS_ALU_RR;  alu_op_c = ALU_OR;  end
      OP_ADDI: begin instr_class_c = CLS_ALU_IMM; alu_op_c = ALU_ADD; end
      OP_ANDI: begin instr_class_c = CLS_ALU_IMM; alu_op_c = ALU_AND; end
      OP_ORI:  begin instr_class_c = CLS_ALU_IMM; alu_op_c = ALU_OR;  end
      // Address generation for loads/stores is base + constant
      OP_LDI:  begin instr_class_c = CLS_LDI;     alu_op_c = ALU_ADD; end
      OP_LD:   begin instr_class_c = CLS_LD;      alu_op_c = ALU_ADD; end
      OP_ST:   begin instr_class_c = CLS_ST;      alu_op_c = ALU_ADD; end
      OP_JR:   instr_class_c = CLS_JR;
      OP_NOP:  instr_class_c = CLS_NOP;
      OP_HALT: instr_class_c = CLS_HALT;
      default: instr_class_c = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch/decode/execute sequencing with memory handshake.
// Define ILLEGAL_OP_TRAP_EN to trap undefined opcodes into HALT with a sticky illegal flag.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IR_W-1:0]  ir,
  input  logic             mem_ack,
  output logic             pc_out,
  output logic             zlow_out,
  output logic             mdr_out,
  output logic             c_out,
  output logic             mar_in,
  output logic             mdr_in,
  output logic             pc_in,
  output logic             ir_in,
  output logic             y_in,
  output logic             z_in,
  output logic             inc_pc,
  output logic             read,
  output logic             write,
  output logic [GR_W-1:0]  gra,
  output logic [GR_W-1:0]  grb,
  output logic [GR_W-1:0]  grc,
  output logic             r_in,
  output logic             r_out,
  output logic             ba_out,
  output logic [ALU_W-1:0] alu_op,
  output logic             run,
  output logic             illegal
);

  ctrl_state_t      state_q, state_d;
  instr_class_t     instr_class_c;
  logic [ALU_W-1:0] dec_alu_op_c;
  ctrl_out_t        ctrl_c;
  logic             run_c;
  logic             unused_ir;

  // Only the opcode field steers sequencing; operand fields go to select-and-encode
  assign unused_ir = ^ir[IR_W-OPC_W-1:0];

  ctrl_opdecode u_opdecode (
    .opcode        (ir[IR_W-1 -: OPC_W]),
    .instr_class_c (instr_class_c),
    .alu_op_c      (dec_alu_op_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RST;
    else          state_q <= state_d;
  end

  // Next-state: wait states hold until mem_ack is sampled high
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (mem_ack) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        case (instr_class_c)
          CLS_ALU_RR, CLS_ALU_IMM, CLS_LDI, CLS_LD, CLS_ST: state_d = ST_T4;
          CLS_HALT:    state_d = ST_HALT;
`ifdef ILLEGAL_OP_TRAP_EN
          CLS_ILLEGAL: state_d = ST_HALT;
`else
          CLS_ILLEGAL: state_d = ST_T0;
`endif
          default:     state_d = ST_T0;
        endcase
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = (instr_class_c == CLS_LD || instr_class_c == CLS_ST) ? ST_T6 : ST_T0;
      ST_T6: begin
        if (instr_class_c == CLS_ST)      state_d = ST_T7;
        else if (instr_class_c != CLS_LD) state_d = ST_T0;
        else if (mem_ack)                 state_d = ST_T7;
      end
      ST_T7: begin
        if (instr_class_c != CLS_ST || mem_ack) state_d = ST_T0;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q | (state_q == ST_T3 && instr_class_c == CLS_ILLEGAL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) illegal_q <= 1'b0;
    else          illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Moore output decode from state and instruction class
  always_comb begin
    ctrl_c        = '0;
    ctrl_c.alu_op = ALU_NOP;
    run_c         = 1'b0;
    case (state_q)
      ST_T0: begin
        run_c = 1'b1;
        ctrl_c.pc_out = 1'b1; ctrl_c.mar_in = 1'b1; ctrl_c.inc_pc = 1'b1; ctrl_c.z_in = 1'b1;
      end
      ST_T1: begin
        run_c = 1'b1;
        ctrl_c.zlow_out = 1'b1; ctrl_c.pc_in = 1'b1; ctrl_c.read = 1'b1; ctrl_c.mdr_in = 1'b1;
      end
      ST_T2: begin
        run_c = 1'b1;
        ctrl_c.mdr_out = 1'b1; ctrl_c.ir_in = 1'b1;
      end
      ST_T3: begin
        run_c = 1'b1;
        case (instr_class_c)
          CLS_ALU_RR, CLS_ALU_IMM: begin
            ctrl_c.grb = GR_SEL; ctrl_c.r_out = 1'b1; ctrl_c.y_in = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            ctrl_c.grb = GR_SEL; ctrl_c.ba_out = 1'b1; ctrl_c.y_in = 1'b1;
          end
          CLS_JR: begin
            ctrl_c.gra = GR_SEL; ctrl_c.r_out = 1'b1; ctrl_c.pc_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        run_c = 1'b1;
        ctrl_c.z_in   = 1'b1;
        ctrl_c.alu_op = dec_alu_op_c;
        if (instr_class_c == CLS_ALU_RR) begin
          ctrl_c.grc = GR_SEL; ctrl_c.r_out = 1'b1;
        end else begin
          ctrl_c.c_out = 1'b1;
        end
      end
      ST_T5: begin
        run_c = 1'b1;
        ctrl_c.zlow_out = 1'b1;
        if (instr_class_c == CLS_LD || instr_class_c == CLS_ST) begin
          ctrl_c.mar_in = 1'b1;
        end else begin
          ctrl_c.gra = GR_SEL; ctrl_c.r_in = 1'b1;
        end
      end
      ST_T6: begin
        run_c = 1'b1;
        ctrl_c.mdr_in = 1'b1;
        if (instr_class_c == CLS_ST) begin
          ctrl_c.gra = GR_SEL; ctrl_c.r_out = 1'b1;
        end else begin
          ctrl_c.read = 1'b1;
        end
      end
      ST_T7: begin
        run_c = 1'b1;
        if (instr_class_c == CLS_ST) begin
          ctrl_c.write = 1'b1;
        end else begin
          ctrl_c.mdr_out = 1'b1; ctrl_c.gra = GR_SEL; ctrl_c.r_in = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pc_out   = ctrl_c.pc_out;
  assign zlow_out = ctrl_c.zlow_out;
  assign mdr_out  = ctrl_c.mdr_out;
  assign c_out    = ctrl_c.c_out;
  assign mar_in   = ctrl_c.mar_in;
  assign mdr_in   = ctrl_c.mdr_in;
  assign pc_in    = ctrl_c.pc_in;
  assign ir_in    = ctrl_c.ir_in;
  assign y_in     = ctrl_c.y_in;
  assign z_in     = ctrl_c.z_in;
  assign inc_pc   = ctrl_c.inc_pc;
  assign read     = ctrl_c.read;
  assign write    = ctrl_c.write;
  assign gra      = ctrl_c.gra;
  assign grb      = ctrl_c.grb;
  assign grc      = ctrl_c.grc;
  assign r_in     = ctrl_c.r_in;
  assign r_out    = ctrl_c.r_out;
  assign ba_out   = ctrl_c.ba_out;
  assign alu_op   = ctrl_c.alu_op;
  assign run      = run_c;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit datapath. It runs the fetch/decode/execute sequence for the reduced instruction subset. Each cycle it drives the register-select strobes (Gra/Grb/Grc, Rin, Rout, BAout) into the select-and-encode stage, plus the bus, ALU and memory control strobes. A Moore FSM decodes the current IR contents and handshakes with memory through an acknowledge input.

## Interface
- No parameters; opcodes and ALU codes are package constants.
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ir  in  32  IR register output; opcode = ir[31:27]
- mem_ack  in  1  memory completed the current Read/Write
- pc_out, zlow_out, mdr_out, c_out  out  1 each  bus drive enables
- mar_in, mdr_in, pc_in, ir_in, y_in, z_in  out  1 each  register load enables
- inc_pc, read, write  out  1 each  PC increment, memory strobes
- gra, grb, grc  out  4 each  field masks to select-and-encode; 4'hF when selected, else 4'h0
- r_in, r_out, ba_out  out  1 each  GP register in/out, base-address out
- alu_op  out  5  ALU operation code
- run  out  1  high while executing; low in RST/HALT
- illegal  out  1  sticky illegal-opcode flag (see Configuration)

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT. Outputs are a pure function of state and ir[31:27].
- Any output not listed for a state is 0.
- Fetch:
  - T0: pc_out, mar_in, inc_pc, z_in.
  - T1: zlow_out, pc_in, read, mdr_in.
  - T2: mdr_out, ir_in.
  - Then T3.
- ALU reg-reg (add 00011, sub 00100, and 00101, or 00110):
  - T3: grb, r_out, y_in.
  - T4: grc, r_out, alu_op=op, z_in.
  - T5: zlow_out, gra, r_in.
  - Then T0.
- ALU immediate (addi 01100, andi 01101, ori 01110): as reg-reg, but T4 uses c_out in place of grc/r_out.
- ldi 00001:
  - T3: grb, ba_out, y_in.
  - T4: c_out, alu_op=ADD, z_in.
  - T5: zlow_out, gra, r_in.
  - Then T0.
- ld 00000:
  - T3–T4 as ldi.
  - T5: zlow_out, mar_in.
  - T6: read, mdr_in (wait state).
  - T7: mdr_out, gra, r_in.
  - Then T0.
- st 00010:
  - T3–T5 as ld.
  - T6: gra, r_out, mdr_in.
  - T7: write (wait state).
  - Then T0.
- jr 10100: T3: gra, r_out, pc_in; then T0.
- nop 11010: T3 with no strobes; then T0.
- halt 11011: T3 goes to HALT. HALT is absorbing until reset.
- alu_op outside T4 is ALU_NOP (5'h00).

## Timing
- Reset asserted: state=RST immediately. All outputs 0, run=0, illegal=0.
- First rising edge after reset_n rises: RST→T0, run=1.
- Memory wait states: T1, ld-T6 and st-T7.
  - The FSM holds in the wait state, keeping its strobes asserted, until a rising edge samples mem_ack=1.
  - mem_ack high in the first cycle gives zero wait cycles.
  - mem_ack outside a wait state is ignored.
- Cycle counts with zero-wait memory:
  - ALU, immediate, ldi: 6 cycles.
  - ld, st: 8 cycles.
  - jr, nop: 4 cycles.
- Each wait cycle adds 1 cycle.
- ir must be stable from T3 through the last execute state. ir_in is asserted only in T2, so ir changes only at the T2→T3 edge.
- Reset mid-instruction (including in a wait state): asynchronous return to RST; read/write deassert immediately.

## Configuration
- ILLEGAL_OP_TRAP_EN defined: an undefined opcode in T3 moves to HALT and sets illegal=1, held until reset.
- ILLEGAL_OP_TRAP_EN undefined: an undefined opcode executes as nop; illegal is tied 0.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams (OP_LD … OP_HALT);
  - ALU code localparams (ALU_NOP, ALU_ADD=5'h03, ALU_SUB=5'h04, ALU_AND=5'h05, ALU_OR=5'h06);
  - the state enum typedef ctrl_state_t.
- One sub-module, ctrl_opdecode: combinational map from opcode to an instruction-class enum (ALU_RR, ALU_IMM, LDI, LD, ST, JR, NOP, HALT, ILLEGAL) and to alu_op.
- Top level holds the state register, next-state logic and output decode.

## Test plan
- Reset release, mem_ack tied 1, ir=add r1,r2,r3 (32'h18918000): states T0..T5 over 6 cycles. T3 grb=4'hF, r_out=1. T4 grc=4'hF, alu_op=5'h03. T5 gra=4'hF, r_in=1. Back to T0.
- ld with mem_ack low 3 cycles in T6: FSM holds T6 with read=1 and mdr_in=1 for 4 cycles total, then T7 with mdr_out=1, r_in=1.
- st with mem_ack held 0: FSM stays in T7 with write=1 indefinitely. Reset pulse clears write asynchronously, state=RST.
- halt (ir[31:27]=5'b11011): T3→HALT, run=0, all strobes 0 for 20 further cycles regardless of mem_ack.
- Opcode 5'b11111 with ILLEGAL_OP_TRAP_EN: HALT, illegal=1. Without the macro: returns to T0 after T3, illegal=0.
- jr with gra field r5: T3 asserts gra=4'hF, r_out=1, pc_in=1. Next state T0 with pc_out=1.
